plic_regmap_pipe: RTL and testbench

PLIC_REGMAP_PIPE -- requirements
Module: plic_regmap_pipe

---
 rtl/plic_regmap_pkg.sv | 27 ++
 rtl/plic_addr_dec.sv | 75 +++++++
 rtl/plic_regmap_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_plic_regmap_pipe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_regmap_pkg.sv
// Shared constants, state/region enums and byte-strobe helper for the PLIC register map.
// Optional feature macro used by this slice: PLIC_EDGE_TRIG_EN (trigger-type words).
package plic_regmap_pkg;

    localparam logic [31:0] PRIO_BASE   = 32'h0000_0000;
    localparam logic [31:0] PEND_BASE   = 32'h0000_1000;
    localparam logic [31:0] TRIG_BASE   = 32'h0000_1080;
    localparam logic [31:0] WORD_SPAN   = 32'h0000_0080;
    localparam logic [31:0] IE_BASE     = 32'h0000_2000;
    localparam logic [31:0] IE_STRIDE   = 32'h0000_0080;
    localparam logic [31:0] CTX_BASE    = 32'h0020_0000;
    localparam logic [31:0] CTX_STRIDE  = 32'h0000_1000;
    localparam logic [31:0] THR_OFF     = 32'h0000_0000;
    localparam logic [31:0] CC_OFF      = 32'h0000_0004;

    typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

    typedef enum logic [2:0] {
        RG_NONE = 3'd0, RG_PRIO = 3'd1, RG_PEND = 3'd2, RG_TRIG = 3'd3,
        RG_IE   = 3'd4, RG_THR  = 3'd5, RG_CC   = 3'd6
    } region_e;

    function automatic logic [31:0] wstrb_mask(input logic [3:0] wstrb);
        return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    endfunction

endpackage

// File: rtl/plic_addr_dec.sv
// Combinational address decoder: region, source/target index, word index and error flag.
// PLIC_EDGE_TRIG_EN maps the trigger-type words; otherwise that range decodes as an error.
module plic_addr_dec
    import plic_regmap_pkg::*;
#(
    parameter int N_SOURCE = 128,
    parameter int N_TARGET = 60
) (
    input  logic [31:0] addr_i,
    input  logic        write_i,
    output region_e     region_o,
    output logic [15:0] idx_o,
    output logic [4:0]  word_o,
    output logic        error_o
);

    localparam logic [31:0] LAST_WORD = 32'(N_SOURCE / 32);
    localparam logic [31:0] NSRC      = 32'(N_SOURCE);
    localparam logic [31:0] NTGT      = 32'(N_TARGET);

    logic [31:0] src_s, word_s, ie_tgt_s, ctx_tgt_s, ctx_off_s, idx_s;
    region_e     hit_s;
    logic        bad_s;

    // Region match with range checks; any error suppresses the region so no side effect follows.
    always_comb begin
        src_s     = {22'd0, addr_i[11:2]};
        word_s    = {27'd0, addr_i[6:2]};
        ie_tgt_s  = (addr_i - IE_BASE) / IE_STRIDE;
        ctx_tgt_s = (addr_i - CTX_BASE) / CTX_STRIDE;
        ctx_off_s = {20'd0, addr_i[11:0]};
        hit_s     = RG_NONE;
        bad_s     = 1'b0;
        idx_s     = 32'd0;
        if (addr_i[1:0] != 2'b00) begin
            bad_s = 1'b1;
        end else if (addr_i < PEND_BASE) begin
            hit_s = RG_PRIO;
            idx_s = src_s;
            bad_s = (src_s > NSRC);
        end else if (addr_i < PEND_BASE + WORD_SPAN) begin
            hit_s = RG_PEND;
            bad_s = write_i || (word_s > LAST_WORD);
        end else if (addr_i < TRIG_BASE + WORD_SPAN) begin
`ifdef PLIC_EDGE_TRIG_EN
            hit_s = RG_TRIG;
            bad_s = (word_s > LAST_WORD);
`else
            bad_s = 1'b1;
`endif
        end else if (addr_i < IE_BASE) begin
            bad_s = 1'b1;
        end else if (addr_i < CTX_BASE) begin
            hit_s = RG_IE;
            idx_s = ie_tgt_s;
            bad_s = (ie_tgt_s >= NTGT) || (word_s > LAST_WORD);
        end else begin
            idx_s = ctx_tgt_s;
            if (ctx_off_s == THR_OFF) begin
                hit_s = RG_THR;
                bad_s = (ctx_tgt_s >= NTGT);
            end else if (ctx_off_s == CC_OFF) begin
                hit_s = RG_CC;
                bad_s = (ctx_tgt_s >= NTGT);
            end else begin
                bad_s = 1'b1;
            end
        end
        region_o = bad_s ? RG_NONE : hit_s;
        idx_o    = bad_s ? 16'd0 : 16'(idx_s);
        word_o   = addr_i[6:2];
        error_o  = bad_s;
    end

endmodule

// File: rtl/plic_regmap_pipe.sv
// PLIC register map behind a valid/ready request/response port, one transaction per two cycles.
// Define PLIC_EDGE_TRIG_EN to add R/W trigger-type words driving trig_o (tied 0 otherwise).
module plic_regmap_pipe
    import plic_regmap_pkg::*;
#(
    parameter int N_SOURCE = 128,
    parameter int N_TARGET = 60,
    parameter int MAX_PRIO = 7,
    parameter int PRIOW    = $clog2(MAX_PRIO + 1),
    parameter int SRCW     = $clog2(N_SOURCE + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic                                req_write_i,
    input  logic [31:0]                         req_addr_i,
    input  logic [31:0]                         req_wdata_i,
    input  logic [3:0]                          req_wstrb_i,
    output logic                                resp_valid_o,
    input  logic                                resp_ready_i,
    output logic [31:0]                         resp_rdata_o,
    output logic                                resp_error_o,
    output logic [N_SOURCE-1:0][PRIOW-1:0]      prio_o,
    output logic [N_TARGET-1:0][N_SOURCE-1:0]   ie_o,
    output logic [N_TARGET-1:0][PRIOW-1:0]      threshold_o,
    input  logic [N_SOURCE:0]                   ip_i,
    input  logic [N_TARGET-1:0][SRCW-1:0]       cc_i,
    output logic [N_TARGET-1:0][SRCW-1:0]       cc_o,
    output logic [N_TARGET-1:0]                 cc_we_o,
    output logic [N_TARGET-1:0]                 cc_re_o,
    output logic [N_SOURCE-1:0]                 trig_o
);

    localparam int TW = (N_TARGET > 1) ? $clog2(N_TARGET) : 1;
    localparam int SW = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1;

    state_e                             state_q, state_d;
    logic                               resp_valid_q, resp_valid_d, error_q, error_d;
    logic [31:0]                        rdata_q, rdata_d;
    logic [N_SOURCE-1:0][PRIOW-1:0]     prio_q, prio_d;
    logic [N_TARGET-1:0][N_SOURCE-1:0]  ie_q, ie_d;
    logic [N_TARGET-1:0][PRIOW-1:0]     thr_q, thr_d;
    logic [N_SOURCE-1:0]                trig_q, trig_d;

    region_e            dec_region_s;
    logic [15:0]        dec_idx_s;
    logic [4:0]         dec_word_s;
    logic               dec_error_s;
    logic [SW-1:0]      src_sel_s;
    logic [TW-1:0]      tgt_sel_s;
    logic [31:0]        mask_s, bits_s, pend_s, rd_s;
    logic [N_SOURCE-1:0] row_s, new_row_s;
    logic [PRIOW-1:0]   sat_s;

    plic_addr_dec #(.N_SOURCE(N_SOURCE), .N_TARGET(N_TARGET)) u_dec (
        .addr_i   (req_addr_i),
        .write_i  (req_write_i),
        .region_o (dec_region_s),
        .idx_o    (dec_idx_s),
        .word_o   (dec_word_s),
        .error_o  (dec_error_s)
    );

    // Sources are 1-based in the address map; state arrays hold source s at entry s-1.
    assign src_sel_s = SW'(dec_idx_s - 16'd1);
    assign tgt_sel_s = TW'(dec_idx_s);
    assign mask_s    = wstrb_mask(req_wstrb_i);
    assign sat_s     = (req_wdata_i > 32'(MAX_PRIO)) ? PRIOW'(MAX_PRIO) : req_wdata_i[PRIOW-1:0];

    // Word view of the selected bit row (enable or trigger) and of the pending vector.
    always_comb begin
        row_s     = (dec_region_s == RG_TRIG) ? trig_q : ie_q[tgt_sel_s];
        new_row_s = row_s;
        bits_s    = 32'd0;
        pend_s    = 32'd0;
        for (int b = 0; b < 32; b++) begin
            int s;
            s = int'(dec_word_s) * 32 + b;
            if (s >= 1 && s <= N_SOURCE) begin
                bits_s[5'(b)]            = row_s[SW'(s - 1)];
                new_row_s[SW'(s - 1)]    = mask_s[5'(b)] ? req_wdata_i[5'(b)] : row_s[SW'(s - 1)];
            end else begin
                bits_s[5'(b)] = 1'b0;
            end
            if (s <= N_SOURCE) begin
                pend_s[5'(b)] = ip_i[SRCW'(s)];
            end else begin
                pend_s[5'(b)] = 1'b0;
            end
        end
    end

    // Read mux over pre-write state.
    always_comb begin
        case (dec_region_s)
            RG_PRIO: rd_s = (dec_idx_s == 16'd0) ? 32'd0 : 32'(prio_q[src_sel_s]);
            RG_PEND: rd_s = pend_s;
            RG_TRIG: rd_s = bits_s;
            RG_IE:   rd_s = bits_s;
            RG_THR:  rd_s = 32'(thr_q[tgt_sel_s]);
            RG_CC:   rd_s = 32'(cc_i[tgt_sel_s]);
            default: rd_s = 32'd0;
        endcase
    end

    // Handshake FSM, register updates and claim/complete strobes on the accept cycle.
    always_comb begin
        state_d      = state_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        prio_d       = prio_q;
        ie_d         = ie_q;
        thr_d        = thr_q;
        trig_d       = trig_q;
        cc_o         = '0;
        cc_we_o      = '0;
        cc_re_o      = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    error_d      = dec_error_s;
                    rdata_d      = req_write_i ? 32'd0 : rd_s;
                    if (req_write_i) begin
                        case (dec_region_s)
                            RG_PRIO: begin
                                if (req_wstrb_i[0] && dec_idx_s != 16'd0) begin
                                    prio_d[src_sel_s] = sat_s;
                                end else begin
                                    prio_d = prio_q;
                                end
                            end
                            RG_TRIG: trig_d = new_row_s;
                            RG_IE:   ie_d[tgt_sel_s] = new_row_s;
                            RG_THR: begin
                                if (req_wstrb_i[0]) begin
                                    thr_d[tgt_sel_s] = sat_s;
                                end else begin
                                    thr_d = thr_q;
                                end
                            end
                            RG_CC: begin
                                if (req_wstrb_i != 4'h0) begin
                                    cc_we_o[tgt_sel_s] = 1'b1;
                                    cc_o[tgt_sel_s]    = req_wdata_i[SRCW-1:0];
                                end else begin
                                    cc_we_o = '0;
                                end
                            end
                            default: prio_d = prio_q;
                        endcase
                    end else if (dec_region_s == RG_CC) begin
                        cc_re_o[tgt_sel_s] = 1'b1;
                    end else begin
                        cc_re_o = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset drops any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            error_q      <= 1'b0;
            prio_q       <= '0;
            ie_q         <= '0;
            thr_q        <= '0;
            trig_q       <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
            prio_q       <= prio_d;
            ie_q         <= ie_d;
            thr_q        <= thr_d;
            trig_q       <= trig_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_error_o = error_q;
    assign prio_o       = prio_q;
    assign ie_o         = ie_q;
    assign threshold_o  = thr_q;
`ifdef PLIC_EDGE_TRIG_EN
    assign trig_o       = trig_q;
`else
    assign trig_o       = '0;
`endif

endmodule

// File: tb/tb_plic_regmap_pipe.sv
// Directed, table-driven bench for plic_regmap_pipe (default parameters).
module tb_plic_regmap_pipe;

    localparam int NS = 128;
    localparam int NT = 60;
    localparam int PW = 3;
    localparam int SW = 8;

    logic                       clk_i = 1'b0;
    logic                       rst_ni = 1'b0;
    logic                       req_valid_i = 1'b0;
    logic                       req_ready_o;
    logic                       req_write_i = 1'b0;
    logic [31:0]                req_addr_i = 32'd0;
    logic [31:0]                req_wdata_i = 32'd0;
    logic [3:0]                 req_wstrb_i = 4'd0;
    logic                       resp_valid_o;
    logic                       resp_ready_i = 1'b1;
    logic [31:0]                resp_rdata_o;
    logic                       resp_error_o;
    logic [NS-1:0][PW-1:0]      prio_o;
    logic [NT-1:0][NS-1:0]      ie_o;
    logic [NT-1:0][PW-1:0]      threshold_o;
    logic [NS:0]                ip_i;
    logic [NT-1:0][SW-1:0]      cc_i;
    logic [NT-1:0][SW-1:0]      cc_o;
    logic [NT-1:0]              cc_we_o;
    logic [NT-1:0]              cc_re_o;
    logic [NS-1:0]              trig_o;

    plic_regmap_pipe dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_error_o(resp_error_o),
        .prio_o(prio_o), .ie_o(ie_o), .threshold_o(threshold_o),
        .ip_i(ip_i), .cc_i(cc_i), .cc_o(cc_o),
        .cc_we_o(cc_we_o), .cc_re_o(cc_re_o), .trig_o(trig_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] rd, input logic er);
        vec_t v;
        v.w = w; v.a = a; v.d = d; v.s = s; v.rd = rd; v.er = er;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic er, output logic vld);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_wdata_i = d; req_wstrb_i = s;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        vld = resp_valid_o; rd = resp_rdata_o; er = resp_error_o;
        @(posedge clk_i); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er, vld;
        logic [NS-1:0][PW-1:0] exp_prio;
        logic [NT-1:0][PW-1:0] exp_thr;
        logic [NS-1:0]         exp_ie0;

        ip_i = {1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D, 32'h8765_4321};
        cc_i = '0;
        cc_i[0] = 8'h33;
        cc_i[1] = 8'd9;

        // write/read/err
        add(1, 32'h0000_000C, 32'h5,         4'hF, 32'h0,         0);
        add(0, 32'h0000_000C, 32'h0,         4'h0, 32'h5,         0);
        add(1, 32'h0000_0004, 32'hFF,        4'hF, 32'h0,         0);
        add(0, 32'h0000_0004, 32'h0,         4'h0, 32'h7,         0);
        add(1, 32'h0000_0008, 32'h3,         4'hE, 32'h0,         0);
        add(0, 32'h0000_0008, 32'h0,         4'h0, 32'h0,         0);
        add(1, 32'h0000_2080, 32'hFFFF_FFFF, 4'h2, 32'h0,         0);
        add(0, 32'h0000_2080, 32'h0,         4'h0, 32'h0000_FF00, 0);
        add(1, 32'h0000_2000, 32'hFFFF_FFFF, 4'hF, 32'h0,         0);
        add(0, 32'h0000_2000, 32'h0,         4'h0, 32'hFFFF_FFFE, 0);
        add(1, 32'h0000_2010, 32'hFFFF_FFFF, 4'hF, 32'h0,         0);
        add(0, 32'h0000_2010, 32'h0,         4'h0, 32'h0000_0001, 0);
        add(0, 32'h0000_2014, 32'h0,         4'h0, 32'h0,         1);
        add(1, 32'h0000_2014, 32'hFFFF_FFFF, 4'hF, 32'h0,         1);
        add(1, 32'h0000_0000, 32'h7,         4'hF, 32'h0,         0);
        add(0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         0);
        add(1, 32'h0000_0200, 32'h6,         4'h1, 32'h0,         0);
        add(0, 32'h0000_0200, 32'h0,         4'h0, 32'h6,         0);
        add(1, 32'h0000_0204, 32'h3,         4'hF, 32'h0,         1);
        add(0, 32'h0000_0002, 32'h0,         4'h0, 32'h0,         1);
        add(1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1);
        add(0, 32'h0023_C000, 32'h0,         4'h0, 32'h0,         1);
        add(1, 32'h0023_C000, 32'h5,         4'hF, 32'h0,         1);
        add(1, 32'h0020_2000, 32'h9,         4'hF, 32'h0,         0);
        add(0, 32'h0020_2000, 32'h0,         4'h0, 32'h7,         0);
        add(1, 32'h0020_0000, 32'h3,         4'hE, 32'h0,         0);
        add(0, 32'h0020_0000, 32'h0,         4'h0, 32'h0,         0);
        add(0, 32'h0020_0008, 32'h0,         4'h0, 32'h0,         1);
        add(0, 32'h0000_1000, 32'h0,         4'h0, 32'h8765_4321, 0);
        add(0, 32'h0000_1004, 32'h0,         4'h0, 32'hCAFE_F00D, 0);
        add(0, 32'h0000_1010, 32'h0,         4'h0, 32'h0000_0001, 0);
        add(0, 32'h0000_1014, 32'h0,         4'h0, 32'h0,         1);
        add(0, 32'h0000_1500, 32'h0,         4'h0, 32'h0,         1);
        add(0, 32'h0000_3E00, 32'h0,         4'h0, 32'h0,         1);
        add(0, 32'h0000_3D90, 32'h0,         4'h0, 32'h0,         0);
`ifdef PLIC_EDGE_TRIG_EN
        add(0, 32'h0000_1080, 32'h0,         4'h0, 32'h0,         0);
`else
        add(0, 32'h0000_1080, 32'h0,         4'h0, 32'h0,         1);
`endif

        // Reset state
        #1;
        chk("rst_outputs", {resp_valid_o, req_ready_o, resp_error_o, resp_rdata_o},
            {1'b0, 1'b1, 1'b0, 32'd0});
        chk("rst_prio", prio_o, 512'd0);
        chk("rst_thr", threshold_o, 512'd0);
        chk("rst_ie0", ie_o[0], 512'd0);
        chk("rst_misc", {trig_o, cc_we_o, cc_re_o}, 512'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_ready", {resp_valid_o, req_ready_o}, {1'b0, 1'b1});

        foreach (vq[i]) begin
            txn(vq[i].w, vq[i].a, vq[i].d, vq[i].s, rd, er, vld);
            chk($sformatf("vec%0d_valid", i), vld, 1'b1);
            chk($sformatf("vec%0d_resp @%h", i, vq[i].a), {er, rd}, {vq[i].er, vq[i].rd});
        end

        exp_prio = '0;
        exp_prio[0] = 3'd7; exp_prio[2] = 3'd5; exp_prio[127] = 3'd6;
        exp_thr = '0;
        exp_thr[2] = 3'd7;
        exp_ie0 = {1'b1, 96'd0, 31'h7FFF_FFFF};
        chk("prio_state", prio_o, exp_prio);
        chk("thr_state", threshold_o, exp_thr);
        chk("ie0_state", ie_o[0], exp_ie0);
        chk("ie1_state", ie_o[1], {384'd0, 128'h7F80});
        chk("ie59_state", ie_o[59], 512'd0);
        chk("trig_state", trig_o, 512'd0);

        // Claim read: strobe only in the accept cycle, data is cc_i[1]
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0020_1004; req_wstrb_i = 4'h0;
        #1;
        chk("claim_strobe", {cc_re_o, cc_we_o}, {60'h2, 60'h0});
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("claim_strobe_end", cc_re_o, 512'd0);
        chk("claim_resp", {resp_valid_o, resp_error_o, resp_rdata_o}, {1'b1, 1'b0, 32'd9});
        @(posedge clk_i); #1;

        // Complete write
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h0020_1004;
        req_wdata_i = 32'd9; req_wstrb_i = 4'hF;
        #1;
        chk("complete_strobe", {cc_we_o, cc_re_o, cc_o[1], cc_o[0]}, {60'h2, 60'h0, 8'd9, 8'd0});
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("complete_strobe_end", cc_we_o, 512'd0);
        @(posedge clk_i); #1;

        // Completion with no strobe bytes does nothing
        @(negedge clk_i);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 32'h0020_1004;
        req_wdata_i = 32'd9; req_wstrb_i = 4'h0;
        #1;
        chk("complete_nostrb", cc_we_o, 512'd0);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(posedge clk_i); #1;

        // Backpressure: response held, no new accept
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_000C; req_wstrb_i = 4'h0;
        @(posedge clk_i); #1;
        req_write_i = 1'b1; req_wdata_i = 32'd1; req_wstrb_i = 4'hF;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold%0d", k), {resp_valid_o, req_ready_o, resp_error_o, resp_rdata_o},
                {1'b1, 1'b0, 1'b0, 32'd5});
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("bp_release", {resp_valid_o, req_ready_o}, {1'b0, 1'b1});
        chk("bp_no_write", prio_o[2], 3'd5);

        // Reset in RESP drops the response
        @(negedge clk_i);
        resp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 32'h0000_0004; req_wstrb_i = 4'h0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        chk("pre_rst_resp", {resp_valid_o, resp_rdata_o}, {1'b1, 32'd7});
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst", {resp_valid_o, req_ready_o, resp_rdata_o, prio_o[0]},
            {1'b0, 1'b1, 32'd0, 3'd0});
        @(negedge clk_i);
        rst_ni = 1'b1;
        resp_ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_i); #1;
            chk($sformatf("no_replay%0d", k), {resp_valid_o, req_ready_o}, {1'b0, 1'b1});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
